// File: rtl/f1_lights_pkg.sv
// f1_lights_pkg: shared types and constants for the F1 start-light controller.
//   state_t           - controller FSM states (IDLE, COUNT, HOLD, GO)
//   LFSR_W            - width of the free-running delay LFSR
//   LFSR_TAPS         - feedback tap mask for x^16+x^14+x^13+x^11+1 (left-shifting)
//   LFSR_SEED_DEFAULT - default (nonzero) reset value of the LFSR
//   lfsr_next()       - one Fibonacci step: shift left, XOR of tapped bits enters bit 0
package f1_lights_pkg;

    localparam int LFSR_W = 16;

    // Bits 15,13,12,10 correspond to polynomial terms x^16, x^14, x^13, x^11.
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2,
        GO    = 2'd3
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/f1_start_lights_ctrl_if.sv
// f1_start_lights_ctrl_if: signal bundle between the tick prescaler / race
// control (master) and the start-light controller (slave).
//   tick       master->slave  one-cycle timebase enable pulse
//   trigger    master->slave  start request level, sampled every cycle
//   abort      master->slave  cancel the running sequence
//   react      master->slave  driver reaction input (jump-start detection)
//   lights     slave->master  lamp drive, bit 0 lights first
//   busy       slave->master  high while a sequence is running (COUNT/HOLD/GO)
//   go         slave->master  one-cycle start pulse
//   jump_start slave->master  sticky early-reaction flag
//   dbg_state  slave->master  current FSM state, for observation only
//
// Handshake semantics: there is no valid/ready pair. tick, trigger, abort and
// react are sampled on every rising clock edge with no acknowledge; a trigger
// that arrives while busy is dropped, not queued. go is a single-cycle pulse
// that the consumer must catch on the cycle it is high.
interface f1_start_lights_ctrl_if #(
    parameter int NUM_LIGHTS = 10
) ();

    logic                     tick;
    logic                     trigger;
    logic                     abort;
    logic                     react;
    logic [NUM_LIGHTS-1:0]    lights;
    logic                     busy;
    logic                     go;
    logic                     jump_start;
    f1_lights_pkg::state_t    dbg_state;

    modport slave (
        input  tick, trigger, abort, react,
        output lights, busy, go, jump_start, dbg_state
    );

    modport master (
        output tick, trigger, abort, react,
        input  lights, busy, go, jump_start, dbg_state
    );

endinterface

// File: rtl/f1_lfsr16.sv
// f1_lfsr16: free-running 16-bit Fibonacci LFSR used as the random hold-time
// source. It advances on every clock edge out of reset, independent of any
// enable, so the value seen at HOLD entry depends on how long the system has
// been running.
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset, loads SEED
//   lfsr_o out  current LFSR register value
module f1_lfsr16
    import f1_lights_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] lfsr_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/f1_start_lights_ctrl.sv
// f1_start_lights_ctrl: F1 start-light sequencer. On trigger it lights
// NUM_LIGHTS lamps one by one every STEP_TICKS ticks, holds them all lit for
// DELAY_MIN + lfsr[DELAY_RND_W-1:0] ticks, then clears them and pulses go.
// abort returns to IDLE from any state without a go pulse.
//   sysclk   in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   bus      slave modport of f1_start_lights_ctrl_if (tick, trigger, abort,
//                 react in; lights, busy, go, jump_start, dbg_state out)
// Optional macro JUMP_DETECT_EN: when defined, react during COUNT or HOLD sets
// the sticky jump_start flag, cleared by reset or an accepted trigger. When
// undefined, react is ignored and jump_start is constant 0.
// All outputs are registered.
module f1_start_lights_ctrl
    import f1_lights_pkg::*;
#(
    parameter int                NUM_LIGHTS  = 10,
    parameter int                STEP_TICKS  = 1,
    parameter int                DELAY_MIN   = 16,
    parameter int                DELAY_RND_W = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    f1_start_lights_ctrl_if.slave bus
);

    localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam int LIT_W  = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
    // Wide enough for DELAY_MIN + (2^DELAY_RND_W - 1) without overflow.
    localparam int DLY_W  = $clog2(DELAY_MIN + (1 << DELAY_RND_W));

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
    localparam logic [LIT_W-1:0]  LIT_LAST  = LIT_W'(NUM_LIGHTS - 1);
    localparam logic [DLY_W-1:0]  DLY_BASE  = DLY_W'(DELAY_MIN);
    localparam logic [DLY_W-1:0]  DLY_ONE   = DLY_W'(1);

    logic [LFSR_W-1:0] lfsr;
    logic              unused_lfsr;

    state_t                state_q,  state_d;
    logic [STEP_W-1:0]     step_q,   step_d;
    logic [LIT_W-1:0]      lit_q,    lit_d;
    logic [DLY_W-1:0]      delay_q,  delay_d;
    logic [NUM_LIGHTS-1:0] lights_q, lights_d;
    logic                  busy_q,   busy_d;
    logic                  go_q,     go_d;

    f1_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (sysclk),
        .rst_n  (rst_n),
        .lfsr_o (lfsr)
    );

    // Only the low DELAY_RND_W bits feed the hold time.
    assign unused_lfsr = ^lfsr;

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        lit_d    = lit_q;
        delay_d  = delay_q;
        lights_d = lights_q;

        if (bus.abort) begin
            state_d  = IDLE;
            step_d   = '0;
            lit_d    = '0;
            delay_d  = '0;
            lights_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // tick is deliberately not looked at in the trigger cycle.
                    if (bus.trigger) begin
                        state_d = COUNT;
                        step_d  = '0;
                        lit_d   = '0;
                    end
                end
                COUNT: begin
                    if (bus.tick) begin
                        if (step_q == STEP_LAST) begin
                            step_d          = '0;
                            lights_d[lit_q] = 1'b1;
                            if (lit_q == LIT_LAST) begin
                                // Last lamp: enter HOLD on the same edge.
                                state_d = HOLD;
                                lit_d   = '0;
                                delay_d = DLY_BASE + DLY_W'(lfsr[DELAY_RND_W-1:0]);
                            end else begin
                                lit_d = lit_q + 1'b1;
                            end
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.tick) begin
                        delay_d = delay_q - 1'b1;
                        if (delay_q == DLY_ONE) begin
                            state_d  = GO;
                            lights_d = '0;
                        end
                    end
                end
                GO: begin
                    state_d  = IDLE;
                    lights_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
        go_d   = (state_d == GO);
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            step_q   <= '0;
            lit_q    <= '0;
            delay_q  <= '0;
            lights_q <= '0;
            busy_q   <= 1'b0;
            go_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            lit_q    <= lit_d;
            delay_q  <= delay_d;
            lights_q <= lights_d;
            busy_q   <= busy_d;
            go_q     <= go_d;
        end
    end

`ifdef JUMP_DETECT_EN
    logic jump_q, jump_d;
    logic trig_accept;

    assign trig_accept = !bus.abort && (state_q == IDLE) && bus.trigger;

    always_comb begin
        jump_d = jump_q;
        if (trig_accept) begin
            jump_d = 1'b0;
        end else if (!bus.abort && bus.react && ((state_q == COUNT) || (state_q == HOLD))) begin
            jump_d = 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            jump_q <= 1'b0;
        end else begin
            jump_q <= jump_d;
        end
    end

    assign bus.jump_start = jump_q;
`else
    logic unused_react;
    assign unused_react   = bus.react;
    assign bus.jump_start = 1'b0;
`endif

    assign bus.lights    = lights_q;
    assign bus.busy      = busy_q;
    assign bus.go        = go_q;
    assign bus.dbg_state = state_q;

endmodule
